// File: rtl/rf_scoreboard_if.sv
// Decode/write-back bundle for the scoreboarded register file.
// The master side is the pipeline (decode plus write-back); the slave side is the register file.
interface rf_scoreboard_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 4
);
  logic [ADDR_W-1:0] p0_addr;
  logic [ADDR_W-1:0] p1_addr;
  logic              re0;
  logic              re1;
  logic [DATA_W-1:0] p0;
  logic [DATA_W-1:0] p1;
  logic              iss_en;
  logic [ADDR_W-1:0] iss_addr;
  logic              iss_full;
  logic [ADDR_W-1:0] dst_addr;
  logic [DATA_W-1:0] dst;
  logic              we;
  logic              busy0;
  logic              busy1;
  logic              hlt;

  modport master (
    output p0_addr, p1_addr, re0, re1, iss_en, iss_addr, dst_addr, dst, we, hlt,
    input  p0, p1, iss_full, busy0, busy1
  );

  modport slave (
    input  p0_addr, p1_addr, re0, re1, iss_en, iss_addr, dst_addr, dst, we, hlt,
    output p0, p1, iss_full, busy0, busy1
  );
endinterface

// File: rtl/rf_scoreboard.sv
// Two-read/one-write register file with registered, write-bypassed reads and a per-register
// outstanding-write counter that drives decode's hazard stalls. R0 is hardwired to zero.
module rf_scoreboard #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned CNT_W  = 2
) (
  input logic               clk,
  input logic               rst,
  rf_scoreboard_if.slave    bus
);
  localparam int unsigned Depth = 2 ** ADDR_W;
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  logic [DATA_W-1:0] mem_q [Depth];
  logic [CNT_W-1:0]  cnt_q [Depth];
  logic [CNT_W-1:0]  cnt_d [Depth];
  logic [DATA_W-1:0] p0_q, p1_q;
  logic [DATA_W-1:0] rd0_val, rd1_val;
  logic              hlt_q;
  logic              iss_full;

  function automatic logic [DATA_W-1:0] read_val(input logic [ADDR_W-1:0] addr,
                                                 input logic              we,
                                                 input logic [ADDR_W-1:0] dst_addr,
                                                 input logic [DATA_W-1:0] dst,
                                                 input logic [DATA_W-1:0] mem_val);
    if (addr == '0) begin
      return '0;
    end else if (we && dst_addr == addr) begin
      return dst;
    end else begin
      return mem_val;
    end
  endfunction

  // A write-back landing on a saturated register frees a slot in the same cycle.
  always_comb begin
    iss_full = bus.iss_en && (bus.iss_addr != '0) && (cnt_q[bus.iss_addr] == CntMax) &&
               !(bus.we && bus.dst_addr == bus.iss_addr);
  end

  always_comb begin
    bus.busy0 = (bus.p0_addr != '0) && (cnt_q[bus.p0_addr] != '0) &&
                !(bus.we && bus.dst_addr == bus.p0_addr && cnt_q[bus.p0_addr] == CNT_W'(1));
    bus.busy1 = (bus.p1_addr != '0) && (cnt_q[bus.p1_addr] != '0) &&
                !(bus.we && bus.dst_addr == bus.p1_addr && cnt_q[bus.p1_addr] == CNT_W'(1));
    bus.iss_full = iss_full;
    bus.p0       = p0_q;
    bus.p1       = p1_q;
  end

  always_comb begin
    rd0_val = read_val(bus.p0_addr, bus.we, bus.dst_addr, bus.dst, mem_q[bus.p0_addr]);
    rd1_val = read_val(bus.p1_addr, bus.we, bus.dst_addr, bus.dst, mem_q[bus.p1_addr]);
  end

  always_comb begin
    for (int r = 0; r < Depth; r++) begin
      logic inc, dec;
      cnt_d[r] = cnt_q[r];
      inc = bus.iss_en && (bus.iss_addr == ADDR_W'(r)) && !iss_full;
      dec = bus.we && (bus.dst_addr == ADDR_W'(r)) && (cnt_q[r] != '0);
      if (r == 0) begin
        cnt_d[r] = '0;
      end else if (inc && !dec) begin
        cnt_d[r] = cnt_q[r] + CNT_W'(1);
      end else if (dec && !inc) begin
        cnt_d[r] = cnt_q[r] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < Depth; r++) begin
        mem_q[r] <= '0;
        cnt_q[r] <= '0;
      end
      p0_q  <= '0;
      p1_q  <= '0;
      hlt_q <= 1'b0;
    end else begin
      if (bus.we && bus.dst_addr != '0) begin
        mem_q[bus.dst_addr] <= bus.dst;
      end
      if (bus.re0) begin
        p0_q <= rd0_val;
      end
      if (bus.re1) begin
        p1_q <= rd1_val;
      end
      for (int r = 0; r < Depth; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      hlt_q <= bus.hlt;
    end
  end

`ifndef SYNTHESIS
  // Register dump on the rising edge of halt; observation only.
  always_ff @(posedge clk) begin
    if (!rst && bus.hlt && !hlt_q) begin
      for (int r = 1; r < Depth; r++) begin
        $display("R%0d = %h", r, mem_q[r]);
      end
    end
  end
`endif
endmodule

// File: tb/tb_rf_scoreboard.sv
// Directed bench for rf_scoreboard: reset, bypass, R0 handling, scoreboard counting,
// saturation, same-cycle busy clear, read hold and mid-run reset.
module tb_rf_scoreboard;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  rf_scoreboard_if #(.DATA_W(16), .ADDR_W(4)) bus ();

  rf_scoreboard #(.DATA_W(16), .ADDR_W(4), .CNT_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.p0_addr  = '0;
    bus.p1_addr  = '0;
    bus.re0      = 1'b0;
    bus.re1      = 1'b0;
    bus.iss_en   = 1'b0;
    bus.iss_addr = '0;
    bus.dst_addr = '0;
    bus.dst      = '0;
    bus.we       = 1'b0;
    bus.hlt      = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rst_p0", 32'(bus.p0), 32'h0);
    check("rst_p1", 32'(bus.p1), 32'h0);
    check("rst_full", 32'(bus.iss_full), 32'h0);

    // All registers read back zero with no hazards.
    for (int r = 1; r < 16; r++) begin
      bus.p0_addr = 4'(r);
      bus.p1_addr = 4'(16 - r);
      bus.re0 = 1'b1;
      bus.re1 = 1'b1;
      #1;
      check($sformatf("rst_busy0_r%0d", r), 32'(bus.busy0), 32'h0);
      check($sformatf("rst_busy1_r%0d", r), 32'(bus.busy1), 32'h0);
      tick();
      check($sformatf("rst_rd0_r%0d", r), 32'(bus.p0), 32'h0);
      check($sformatf("rst_rd1_r%0d", r), 32'(bus.p1), 32'h0);
    end
    idle();

    // Same-cycle write bypass into read port 0; port 1 disabled holds.
    bus.we = 1'b1; bus.dst_addr = 4'd3; bus.dst = 16'hBEEF;
    bus.p0_addr = 4'd3; bus.re0 = 1'b1;
    bus.p1_addr = 4'd3; bus.re1 = 1'b0;
    tick();
    idle();
    check("bypass_p0", 32'(bus.p0), 32'hBEEF);
    check("bypass_p1_hold", 32'(bus.p1), 32'h0);

    // Writes to R0 are dropped and R0 never reports busy.
    bus.we = 1'b1; bus.dst_addr = 4'd0; bus.dst = 16'h1234;
    bus.p0_addr = 4'd0; bus.re0 = 1'b1;
    tick();
    check("r0_bypass", 32'(bus.p0), 32'h0);
    idle();
    bus.p0_addr = 4'd0; bus.re0 = 1'b1;
    bus.iss_en = 1'b1; bus.iss_addr = 4'd0;
    #1;
    check("r0_iss_full", 32'(bus.iss_full), 32'h0);
    tick();
    bus.iss_en = 1'b0;
    #1;
    check("r0_read", 32'(bus.p0), 32'h0);
    check("r0_busy", 32'(bus.busy0), 32'h0);
    idle();

    // Three issues to R5 fill its counter.
    for (int i = 0; i < 3; i++) begin
      bus.iss_en = 1'b1; bus.iss_addr = 4'd5;
      #1;
      check($sformatf("iss5_full_%0d", i), 32'(bus.iss_full), 32'h0);
      tick();
    end
    bus.p0_addr = 4'd5;
    #1;
    check("iss5_full_sat", 32'(bus.iss_full), 32'h1);
    check("iss5_busy0", 32'(bus.busy0), 32'h1);
    tick();  // refused issue: counter stays at 3
    // Simultaneous write-back frees the slot; inc and dec cancel.
    bus.we = 1'b1; bus.dst_addr = 4'd5; bus.dst = 16'h0055;
    #1;
    check("iss5_full_we", 32'(bus.iss_full), 32'h0);
    tick();
    bus.iss_en = 1'b0;
    // Drain: 3 -> 2 -> 1, busy stays up until the last write lands.
    bus.we = 1'b0; bus.p1_addr = 4'd5;
    #1;
    check("drain_busy1_3", 32'(bus.busy1), 32'h1);
    bus.we = 1'b1;
    #1;
    check("drain_busy0_3", 32'(bus.busy0), 32'h1);
    tick();
    #1;
    check("drain_busy0_2", 32'(bus.busy0), 32'h1);
    tick();
    bus.we = 1'b0;
    #1;
    check("drain_busy1_1_nowe", 32'(bus.busy1), 32'h1);
    bus.we = 1'b1;
    #1;
    check("drain_busy1_1_we", 32'(bus.busy1), 32'h0);
    check("drain_busy0_1_we", 32'(bus.busy0), 32'h0);
    tick();
    bus.we = 1'b0;
    #1;
    check("drain_busy0_0", 32'(bus.busy0), 32'h0);
    // Write with counter already zero must not underflow.
    bus.we = 1'b1;
    tick();
    bus.we = 1'b0;
    #1;
    check("no_underflow", 32'(bus.busy0), 32'h0);
    bus.iss_en = 1'b1; bus.iss_addr = 4'd5;
    #1;
    check("no_underflow_full", 32'(bus.iss_full), 32'h0);
    tick();
    bus.iss_en = 1'b0;
    #1;
    check("one_busy0", 32'(bus.busy0), 32'h1);
    bus.we = 1'b1;
    tick();
    idle();

    // Read-enable low holds the last value across a write.
    bus.p0_addr = 4'd3; bus.re0 = 1'b1;
    tick();
    check("hold_pre", 32'(bus.p0), 32'hBEEF);
    bus.re0 = 1'b0;
    bus.we = 1'b1; bus.dst_addr = 4'd3; bus.dst = 16'h0001;
    tick();
    check("hold_p0", 32'(bus.p0), 32'hBEEF);
    bus.we = 1'b0; bus.re0 = 1'b1;
    tick();
    check("hold_after", 32'(bus.p0), 32'h0001);
    idle();

    // Reset mid-operation discards data and pending counts.
    bus.iss_en = 1'b1; bus.iss_addr = 4'd7;
    tick();
    tick();
    tick();
    bus.p1_addr = 4'd7;
    #1;
    check("pre_rst_full", 32'(bus.iss_full), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("mid_rst_full", 32'(bus.iss_full), 32'h0);
    check("mid_rst_busy1", 32'(bus.busy1), 32'h0);
    check("mid_rst_p0", 32'(bus.p0), 32'h0);
    bus.iss_en = 1'b0;
    bus.p0_addr = 4'd3; bus.re0 = 1'b1;
    tick();
    check("mid_rst_mem", 32'(bus.p0), 32'h0);
    idle();

    bus.hlt = 1'b1;
    tick();
    tick();
    bus.hlt = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
